// File: rtl/tw_pkg.sv
// Shared definitions for the tw_* twiddle loaders: FSM state encodings and a
// constant-evaluable ceil(log2) helper.
package tw_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_READY = 2'd2;
    localparam logic [1:0] ST_ERR   = 2'd3;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((32'sd1 <<< result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/tw_ram_loader_if.sv
// Valid/ready twiddle stream carrying one value per beat plus an end-of-table marker.
interface tw_ram_loader_if #(
    parameter int LOGQ = 60
);
    logic            s_valid;
    logic            s_ready;
    logic            s_last;
    logic [LOGQ-1:0] s_data;

    modport master (output s_valid, output s_data, output s_last, input  s_ready);
    modport slave  (input  s_valid, input  s_data, input  s_last, output s_ready);
endinterface

// File: rtl/tw_ram_sdp.sv
// Simple dual-port twiddle RAM: one write port, one read port with a DELAY-deep
// resettable output pipeline (read-during-write to the same address returns old data).
module tw_ram_sdp #(
    parameter int DW    = 60,
    parameter int AW    = 12,
    parameter int DELAY = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem_r  [0:(2**AW)-1];
    logic [DW-1:0] pipe_r [0:DELAY-1];

    // Write port; storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    // Read pipeline: first stage samples the array, the rest delay it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DELAY; i++) begin
                pipe_r[i] <= {DW{1'b0}};
            end
        end else begin
            pipe_r[0] <= mem_r[raddr];
            for (int i = 1; i < DELAY; i++) begin
                pipe_r[i] <= pipe_r[i-1];
            end
        end
    end

    assign rdata = pipe_r[DELAY-1];
endmodule

// File: rtl/tw_ram_loader.sv
// Runtime-writable twiddle store for one NTT stage: loads a stream into a stage RAM,
// checks its length (and value range when TW_RANGE_CHECK_EN is defined), then serves reads.
module tw_ram_loader
    import tw_pkg::*;
#(
    parameter int              LOGQ       = 60,
    parameter int              LOGN       = 12,
    parameter int              NUM_TW     = 2048,
    parameter int              STAGE      = 1,
    parameter int              DELAY_BROM = 2,
    parameter int              TYPE_RED   = 0,
    parameter logic [LOGQ-1:0] R_w        = {LOGQ{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [LOGQ-1:0]  q,
    input  logic             start,
    tw_ram_loader_if.slave   s_if,
    output logic             done,
    output logic             err,
    output logic             tw_valid,
    input  logic [LOGN-1:0]  raddr,
    output logic [LOGQ-1:0]  dout
);
    generate
        if (STAGE == 0) begin : g_const
            // Stage 0 uses a single constant twiddle, so nothing is stored or loaded.
            logic unused_s;
            assign unused_s   = ^{clk, rst_n, q, start, s_if.s_valid, s_if.s_data, s_if.s_last, raddr};
            assign s_if.s_ready = 1'b0;
            assign done       = 1'b0;
            assign err        = 1'b0;
            assign tw_valid   = 1'b1;
            assign dout       = (TYPE_RED != 0) ? R_w : {{(LOGQ-1){1'b0}}, 1'b1};
        end else begin : g_ram
            localparam int CNT_W = clog2(NUM_TW + 1);

            logic [1:0]       state_r, next_state_s;
            logic [CNT_W-1:0] wptr_r;
            logic             s_ready_r, done_r, err_r, tw_valid_r;
            logic             s_ready_d_s, done_d_s, err_d_s, tw_valid_d_s;
            logic             accept_s, last_idx_s, range_hit_s, load_go_s;

            assign accept_s   = (state_r == ST_LOAD) && s_if.s_valid && s_ready_r;
            assign last_idx_s = (wptr_r == CNT_W'(NUM_TW - 1));
            assign load_go_s  = (state_r != ST_LOAD) && start;

`ifdef TW_RANGE_CHECK_EN
            logic range_err_r;
            // The current beat's own range violation counts toward the terminating decision.
            assign range_hit_s = range_err_r || (s_if.s_data >= q);

            // Sticky range flag for the load in progress.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    range_err_r <= 1'b0;
                end else if (load_go_s) begin
                    range_err_r <= 1'b0;
                end else if (accept_s && (s_if.s_data >= q)) begin
                    range_err_r <= 1'b1;
                end else begin
                    range_err_r <= range_err_r;
                end
            end
`else
            logic unused_q_s;
            assign unused_q_s  = ^q;
            assign range_hit_s = 1'b0;
`endif

            // FSM state register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_r <= ST_IDLE;
                end else begin
                    state_r <= next_state_s;
                end
            end

            // Next-state logic: termination is judged on every accepted beat.
            always_comb begin
                next_state_s = state_r;
                case (state_r)
                    ST_IDLE, ST_READY, ST_ERR: begin
                        if (start) next_state_s = ST_LOAD;
                        else       next_state_s = state_r;
                    end
                    ST_LOAD: begin
                        if (accept_s) begin
                            if (s_if.s_last) begin
                                if (last_idx_s && !range_hit_s) next_state_s = ST_READY;
                                else                            next_state_s = ST_ERR;
                            end else if (last_idx_s) begin
                                next_state_s = ST_ERR;
                            end else begin
                                next_state_s = ST_LOAD;
                            end
                        end else begin
                            next_state_s = ST_LOAD;
                        end
                    end
                    default: next_state_s = ST_IDLE;
                endcase
            end

            // Output decode from the upcoming state so every output is registered.
            always_comb begin
                s_ready_d_s  = (next_state_s == ST_LOAD);
                done_d_s     = (state_r == ST_LOAD) && (next_state_s == ST_READY);
                err_d_s      = (next_state_s == ST_ERR);
                tw_valid_d_s = (next_state_s == ST_READY);
            end

            // Output and write-pointer registers.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s_ready_r  <= 1'b0;
                    done_r     <= 1'b0;
                    err_r      <= 1'b0;
                    tw_valid_r <= 1'b0;
                    wptr_r     <= {CNT_W{1'b0}};
                end else begin
                    s_ready_r  <= s_ready_d_s;
                    done_r     <= done_d_s;
                    err_r      <= err_d_s;
                    tw_valid_r <= tw_valid_d_s;
                    if (load_go_s)     wptr_r <= {CNT_W{1'b0}};
                    else if (accept_s) wptr_r <= wptr_r + CNT_W'(1);
                    else               wptr_r <= wptr_r;
                end
            end

            assign s_if.s_ready = s_ready_r;
            assign done         = done_r;
            assign err          = err_r;
            assign tw_valid     = tw_valid_r;

            tw_ram_sdp #(
                .DW    (LOGQ),
                .AW    (LOGN),
                .DELAY (DELAY_BROM)
            ) u_ram (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (accept_s),
                .waddr (LOGN'(wptr_r)),
                .wdata (s_if.s_data),
                .raddr (raddr),
                .rdata (dout)
            );
        end
    endgenerate
endmodule

// File: tb/tb_tw_ram_loader.sv
// Directed self-checking bench for tw_ram_loader (8-entry table, two-cycle read, plus stage-0 variants).
module tb_tw_ram_loader;
    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] q;
    logic [3:0] raddr;
    logic       done, err, tw_valid;
    logic [7:0] dout;
    logic       done0, err0, twv0;
    logic [7:0] dout0;
    logic       done1, err1, twv1;
    logic [7:0] dout1;
    int         checks;
    int         failures;

    tw_ram_loader_if #(.LOGQ(8)) bus  ();
    tw_ram_loader_if #(.LOGQ(8)) bus0 ();
    tw_ram_loader_if #(.LOGQ(8)) bus1 ();

    tw_ram_loader #(.LOGQ(8), .LOGN(4), .NUM_TW(8), .STAGE(1), .DELAY_BROM(2)) dut (
        .clk(clk), .rst_n(rst_n), .q(q), .start(start), .s_if(bus.slave),
        .done(done), .err(err), .tw_valid(tw_valid), .raddr(raddr), .dout(dout));

    tw_ram_loader #(.LOGQ(8), .LOGN(4), .NUM_TW(8), .STAGE(0), .TYPE_RED(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .q(q), .start(start), .s_if(bus0.slave),
        .done(done0), .err(err0), .tw_valid(twv0), .raddr(raddr), .dout(dout0));

    tw_ram_loader #(.LOGQ(8), .LOGN(4), .NUM_TW(8), .STAGE(0), .TYPE_RED(1), .R_w(8'd5)) dut_s1 (
        .clk(clk), .rst_n(rst_n), .q(q), .start(start), .s_if(bus1.slave),
        .done(done1), .err(err1), .tw_valid(twv1), .raddr(raddr), .dout(dout1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // All tasks begin and end on a falling edge.
    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] d, input logic l, output logic acc);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        bus.s_last  = l;
        acc         = bus.s_ready;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    task automatic load_table(input logic [7:0] base, input bit gaps);
        logic acc;
        for (int i = 0; i < 8; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            send_beat(base + 8'(i), (i == 7), acc);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL rst_s_ready got=%0b exp=0", bus.s_ready); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL rst_done got=%0b exp=0", done); end
        checks++; if (err !== 1'b0)         begin failures++; $display("FAIL rst_err got=%0b exp=0", err); end
        checks++; if (tw_valid !== 1'b0)    begin failures++; $display("FAIL rst_tw_valid got=%0b exp=0", tw_valid); end
        checks++; if (dout !== 8'd0)        begin failures++; $display("FAIL rst_dout got=%0d exp=0", dout); end
        checks++; if (twv0 !== 1'b1)        begin failures++; $display("FAIL rst_s0_tw_valid got=%0b exp=1", twv0); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_full_load();
        raddr = 4'd0;
        do_start();
        checks++; if (bus.s_ready !== 1'b1) begin failures++; $display("FAIL load_s_ready got=%0b exp=1", bus.s_ready); end
        load_table(8'd1, 1'b0);
        checks++; if (done !== 1'b1)        begin failures++; $display("FAIL full_done got=%0b exp=1", done); end
        checks++; if (tw_valid !== 1'b1)    begin failures++; $display("FAIL full_tw_valid got=%0b exp=1", tw_valid); end
        checks++; if (err !== 1'b0)         begin failures++; $display("FAIL full_err got=%0b exp=0", err); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL full_s_ready got=%0b exp=0", bus.s_ready); end
        @(negedge clk);
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL done_pulse got=%0b exp=0", done); end
        raddr = 4'd3;
        @(negedge clk);
        checks++; if (dout !== 8'd1)        begin failures++; $display("FAIL read_lat1 got=%0d exp=1", dout); end
        @(negedge clk);
        checks++; if (dout !== 8'd4)        begin failures++; $display("FAIL read_lat2 got=%0d exp=4", dout); end
    endtask

    task automatic test_rdw();
        logic acc;
        raddr = 4'd0;
        repeat (2) @(negedge clk);
        do_start();
        send_beat(8'd9, 1'b0, acc);
        send_beat(8'd10, 1'b0, acc);
        checks++; if (dout !== 8'd1)  begin failures++; $display("FAIL rdw_old got=%0d exp=1", dout); end
        send_beat(8'd11, 1'b0, acc);
        checks++; if (dout !== 8'd9)  begin failures++; $display("FAIL rdw_new got=%0d exp=9", dout); end
        for (int i = 3; i < 8; i++) send_beat(8'(9 + i), (i == 7), acc);
        checks++; if (done !== 1'b1)  begin failures++; $display("FAIL rdw_done got=%0b exp=1", done); end
    endtask

    task automatic test_short();
        logic acc;
        do_start();
        checks++; if (tw_valid !== 1'b0) begin failures++; $display("FAIL short_tw_clear got=%0b exp=0", tw_valid); end
        for (int i = 0; i < 5; i++) send_beat(8'(30 + i), (i == 4), acc);
        checks++; if (err !== 1'b1)         begin failures++; $display("FAIL short_err got=%0b exp=1", err); end
        checks++; if (tw_valid !== 1'b0)    begin failures++; $display("FAIL short_tw_valid got=%0b exp=0", tw_valid); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL short_s_ready got=%0b exp=0", bus.s_ready); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL short_done got=%0b exp=0", done); end
        do_start();
        checks++; if (err !== 1'b0)         begin failures++; $display("FAIL short_err_clear got=%0b exp=0", err); end
        load_table(8'd1, 1'b0);
        checks++; if (done !== 1'b1)        begin failures++; $display("FAIL short_reload_done got=%0b exp=1", done); end
    endtask

    task automatic test_long();
        logic acc;
        do_start();
        for (int i = 0; i < 8; i++) send_beat(8'(40 + i), 1'b0, acc);
        checks++; if (err !== 1'b1)         begin failures++; $display("FAIL long_err got=%0b exp=1", err); end
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL long_s_ready got=%0b exp=0", bus.s_ready); end
        send_beat(8'd48, 1'b1, acc);
        checks++; if (acc !== 1'b0)         begin failures++; $display("FAIL long_ninth_accept got=%0b exp=0", acc); end
        checks++; if (done !== 1'b0)        begin failures++; $display("FAIL long_done got=%0b exp=0", done); end
        checks++; if (err !== 1'b1)         begin failures++; $display("FAIL long_err_sticky got=%0b exp=1", err); end
    endtask

    task automatic test_range();
        logic acc;
        q = 8'd17;
        do_start();
        for (int i = 0; i < 8; i++) send_beat((i == 2) ? 8'd17 : 8'(i + 1), (i == 7), acc);
`ifdef TW_RANGE_CHECK_EN
        checks++; if (err !== 1'b1)      begin failures++; $display("FAIL range_err got=%0b exp=1", err); end
        checks++; if (done !== 1'b0)     begin failures++; $display("FAIL range_done got=%0b exp=0", done); end
        checks++; if (tw_valid !== 1'b0) begin failures++; $display("FAIL range_tw_valid got=%0b exp=0", tw_valid); end
`else
        checks++; if (done !== 1'b1)     begin failures++; $display("FAIL range_done got=%0b exp=1", done); end
        checks++; if (err !== 1'b0)      begin failures++; $display("FAIL range_err got=%0b exp=0", err); end
        raddr = 4'd2;
        repeat (2) @(negedge clk);
        checks++; if (dout !== 8'd17)    begin failures++; $display("FAIL range_mem2 got=%0d exp=17", dout); end
`endif
    endtask

    task automatic test_reset_mid_load();
        logic acc;
        do_start();
        for (int i = 0; i < 4; i++) send_beat(8'(60 + i), 1'b0, acc);
        rst_n = 1'b0;
        #1;
        checks++; if (bus.s_ready !== 1'b0) begin failures++; $display("FAIL midrst_s_ready got=%0b exp=0", bus.s_ready); end
        checks++; if (err !== 1'b0)         begin failures++; $display("FAIL midrst_err got=%0b exp=0", err); end
        checks++; if (tw_valid !== 1'b0)    begin failures++; $display("FAIL midrst_tw_valid got=%0b exp=0", tw_valid); end
        checks++; if (dout !== 8'd0)        begin failures++; $display("FAIL midrst_dout got=%0d exp=0", dout); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (tw_valid !== 1'b0)    begin failures++; $display("FAIL midrst_partial got=%0b exp=0", tw_valid); end
        do_start();
        load_table(8'd50, 1'b1);
        checks++; if (tw_valid !== 1'b1)    begin failures++; $display("FAIL gaps_tw_valid got=%0b exp=1", tw_valid); end
        for (int i = 0; i < 8; i++) begin
            raddr = 4'(i);
            repeat (2) @(negedge clk);
            checks++;
            if (dout !== 8'(50 + i)) begin
                failures++;
                $display("FAIL gaps_mem[%0d] got=%0d exp=%0d", i, dout, 50 + i);
            end
        end
    endtask

    task automatic test_stage0();
        checks++; if (dout0 !== 8'd1) begin failures++; $display("FAIL s0_dout_tr0 got=%0d exp=1", dout0); end
        checks++; if (dout1 !== 8'd5) begin failures++; $display("FAIL s0_dout_tr1 got=%0d exp=5", dout1); end
        bus0.s_valid = 1'b1;
        bus1.s_valid = 1'b1;
        do_start();
        @(negedge clk);
        checks++; if (bus0.s_ready !== 1'b0) begin failures++; $display("FAIL s0_s_ready got=%0b exp=0", bus0.s_ready); end
        checks++; if (bus1.s_ready !== 1'b0) begin failures++; $display("FAIL s1_s_ready got=%0b exp=0", bus1.s_ready); end
        checks++; if (twv0 !== 1'b1)  begin failures++; $display("FAIL s0_tw_valid got=%0b exp=1", twv0); end
        checks++; if (twv1 !== 1'b1)  begin failures++; $display("FAIL s1_tw_valid got=%0b exp=1", twv1); end
        checks++; if (err0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL s0_err_done got=%0b%0b exp=00", err0, done0); end
        checks++; if (err1 !== 1'b0 || done1 !== 1'b0) begin failures++; $display("FAIL s1_err_done got=%0b%0b exp=00", err1, done1); end
        checks++; if (dout1 !== 8'd5) begin failures++; $display("FAIL s0_dout_after_start got=%0d exp=5", dout1); end
        bus0.s_valid = 1'b0;
        bus1.s_valid = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        q            = 8'd17;
        raddr        = 4'd0;
        bus.s_valid  = 1'b0; bus.s_data  = 8'd0; bus.s_last  = 1'b0;
        bus0.s_valid = 1'b0; bus0.s_data = 8'd0; bus0.s_last = 1'b0;
        bus1.s_valid = 1'b0; bus1.s_data = 8'd0; bus1.s_last = 1'b0;
        test_reset();
        test_full_load();
        test_rdw();
        test_short();
        test_long();
        test_range();
        test_reset_mid_load();
        test_stage0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
